conv_mac_seq: RTL and testbench

Parametrised, time-multiplexed KxK convolution MAC engine for the CNN datapath.
- Accepts one image window plus kernel through a valid/ready handshake.
- Each cycle it multiplies one column of the window: KSIZE products, one per kernel row.
- It accumulates those products into a wide register over KSIZE cycles.
- It then presents a single result, with optional signed arithmetic and ReLU, through a valid/ready output handshake.

---
 rtl/conv_mac_if.sv | 26 ++
 rtl/conv_mac_seq.sv | 149 ++++++++++++++
 tb/tb_conv_mac_seq.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/conv_mac_if.sv
// Window/kernel request and result response bundle for the KxK convolution MAC.
interface conv_mac_if #(
    parameter int DATA_W = 8,
    parameter int KSIZE  = 3,
    parameter int ACC_W  = 20
);
    logic                            in_valid;
    logic                            in_ready;
    logic [KSIZE*KSIZE*DATA_W-1:0]   image_flat;
    logic [KSIZE*KSIZE*DATA_W-1:0]   kernel_flat;
    logic                            abort;
    logic                            out_valid;
    logic                            out_ready;
    logic [ACC_W-1:0]                result;
    logic                            busy;

    modport master (
        output in_valid, image_flat, kernel_flat, abort, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, image_flat, kernel_flat, abort, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/conv_mac_seq.sv
// Time-multiplexed KxK convolution MAC: one window column (KSIZE products)
// per cycle, KSIZE cycles per window, result held until the consumer takes it.
module conv_mac_seq #(
    parameter int DATA_W = 8,
    parameter int KSIZE  = 3,
    parameter int ACC_W  = 20,
    parameter int SIGNED = 0,
    parameter int RELU   = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    conv_mac_if.slave  bus
);
    localparam int N  = KSIZE * KSIZE;
    localparam int CW = $clog2(KSIZE);
    localparam int PW = 2 * DATA_W;

    // Accumulator must hold the full sum of N maximal products.
    if (ACC_W < PW + $clog2(N)) begin : g_acc_too_narrow
        $error("conv_mac_seq: ACC_W too small for DATA_W/KSIZE");
    end
    if (KSIZE < 2) begin : g_ksize_too_small
        $error("conv_mac_seq: KSIZE must be at least 2");
    end

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                state_q, state_d;
    logic [N*DATA_W-1:0]   img_q, ker_q;
    logic [ACC_W-1:0]      acc_q, res_q;
    logic [CW-1:0]         col_q;
    logic [ACC_W-1:0]      col_sum, acc_nxt, res_nxt;
    logic                  last_col, accept;
    logic                  in_ready, out_valid, busy;

    // Unpacked views of the captured operands so the current column is a plain index.
    logic [DATA_W-1:0]     img_e [KSIZE][KSIZE];
    logic [DATA_W-1:0]     ker_e [KSIZE][KSIZE];
    logic [ACC_W-1:0]      prod_ext [KSIZE];

    for (genvar r = 0; r < KSIZE; r++) begin : g_r
        for (genvar c = 0; c < KSIZE; c++) begin : g_c
            assign img_e[r][c] = img_q[(r*KSIZE+c)*DATA_W +: DATA_W];
            assign ker_e[r][c] = ker_q[(r*KSIZE+c)*DATA_W +: DATA_W];
        end
    end

    // One multiplier per kernel row; operands extended to 2*DATA_W first so the
    // low 2*DATA_W bits of the product are exact for either signedness.
    for (genvar r = 0; r < KSIZE; r++) begin : g_row
        logic [DATA_W-1:0] a, b;
        logic [PW-1:0]     p;
        assign a = img_e[r][col_q];
        assign b = ker_e[r][col_q];
        if (SIGNED != 0) begin : g_s
            logic [PW-1:0] a_x, b_x;
            assign a_x = {{DATA_W{a[DATA_W-1]}}, a};
            assign b_x = {{DATA_W{b[DATA_W-1]}}, b};
            assign p   = a_x * b_x;
            assign prod_ext[r] = {{(ACC_W-PW){p[PW-1]}}, p};
        end else begin : g_u
            logic [PW-1:0] a_x, b_x;
            assign a_x = {{DATA_W{1'b0}}, a};
            assign b_x = {{DATA_W{1'b0}}, b};
            assign p   = a_x * b_x;
            assign prod_ext[r] = {{(ACC_W-PW){1'b0}}, p};
        end
    end

    // Column sum, running total and the (optionally rectified) final value.
    always_comb begin
        col_sum = '0;
        for (int r = 0; r < KSIZE; r++) col_sum = col_sum + prod_ext[r];
        acc_nxt = acc_q + col_sum;
        res_nxt = acc_nxt;
        if (SIGNED != 0 && RELU != 0 && acc_nxt[ACC_W-1]) res_nxt = '0;
    end

    assign last_col = (col_q == CW'(KSIZE-1));
    // abort beats a new offer while idle.
    assign accept   = (state_q == IDLE) && bus.in_valid && !bus.abort;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ACCUM;
            ACCUM:   if (bus.abort) state_d = IDLE;
                     else if (last_col) state_d = DONE;
            DONE:    if (bus.abort || bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake/status outputs decoded from state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE:    in_ready = 1'b1;
            ACCUM:   busy = 1'b1;
            DONE:    begin out_valid = 1'b1; busy = 1'b1; end
            default: in_ready = 1'b0;
        endcase
    end

    // Operand capture, column accumulation and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            img_q <= '0;
            ker_q <= '0;
            acc_q <= '0;
            col_q <= '0;
            res_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    img_q <= bus.image_flat;
                    ker_q <= bus.kernel_flat;
                    acc_q <= '0;
                    col_q <= '0;
                end
                ACCUM: if (bus.abort) begin
                    col_q <= '0;
                end else if (last_col) begin
                    acc_q <= acc_nxt;
                    res_q <= res_nxt;
                    col_q <= '0;
                end else begin
                    acc_q <= acc_nxt;
                    col_q <= col_q + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.busy      = busy;
    assign bus.result    = res_q;
endmodule

// File: tb/tb_conv_mac_seq.sv
// Directed bench: three 3x3 engines (unsigned, signed, signed+ReLU) driven in
// lockstep with identical stimulus, plus a 5x5 unsigned engine.
module tb_conv_mac_seq;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        in_valid, abort, out_ready;
    logic [71:0] img, ker;
    logic        k5_valid;
    logic [199:0] k5_img, k5_ker;

    conv_mac_if #(.DATA_W(8), .KSIZE(3), .ACC_W(20)) if_u ();
    conv_mac_if #(.DATA_W(8), .KSIZE(3), .ACC_W(20)) if_s ();
    conv_mac_if #(.DATA_W(8), .KSIZE(3), .ACC_W(20)) if_r ();
    conv_mac_if #(.DATA_W(8), .KSIZE(5), .ACC_W(21)) if_5 ();

    assign if_u.in_valid = in_valid;  assign if_s.in_valid = in_valid;  assign if_r.in_valid = in_valid;
    assign if_u.image_flat = img;     assign if_s.image_flat = img;     assign if_r.image_flat = img;
    assign if_u.kernel_flat = ker;    assign if_s.kernel_flat = ker;    assign if_r.kernel_flat = ker;
    assign if_u.abort = abort;        assign if_s.abort = abort;        assign if_r.abort = abort;
    assign if_u.out_ready = out_ready; assign if_s.out_ready = out_ready; assign if_r.out_ready = out_ready;
    assign if_5.in_valid = k5_valid;
    assign if_5.image_flat = k5_img;
    assign if_5.kernel_flat = k5_ker;
    assign if_5.abort = 1'b0;
    assign if_5.out_ready = 1'b1;

    conv_mac_seq #(.DATA_W(8), .KSIZE(3), .ACC_W(20), .SIGNED(0), .RELU(0))
        u_u (.clk(clk), .rst_n(rst_n), .bus(if_u.slave));
    conv_mac_seq #(.DATA_W(8), .KSIZE(3), .ACC_W(20), .SIGNED(1), .RELU(0))
        u_s (.clk(clk), .rst_n(rst_n), .bus(if_s.slave));
    conv_mac_seq #(.DATA_W(8), .KSIZE(3), .ACC_W(20), .SIGNED(1), .RELU(1))
        u_r (.clk(clk), .rst_n(rst_n), .bus(if_r.slave));
    conv_mac_seq #(.DATA_W(8), .KSIZE(5), .ACC_W(21), .SIGNED(0), .RELU(0))
        u_5 (.clk(clk), .rst_n(rst_n), .bus(if_5.slave));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] fill3(input logic [7:0] v);
        logic [71:0] f;
        for (int i = 0; i < 9; i++) f[i*8 +: 8] = v;
        return f;
    endfunction

    function automatic logic [199:0] fill5(input logic [7:0] v);
        logic [199:0] f;
        for (int i = 0; i < 25; i++) f[i*8 +: 8] = v;
        return f;
    endfunction

    function automatic logic [71:0] seq9();
        logic [71:0] f;
        for (int i = 0; i < 9; i++) f[i*8 +: 8] = 8'(i + 1);
        return f;
    endfunction

    // Offer a window at the current negedge; returns at the negedge after the accept edge.
    task automatic start(input logic [71:0] im, input logic [71:0] ke, input string tag);
        img = im; ker = ke; in_valid = 1'b1;
        chk({tag, "_rdy_pre"}, 32'(if_u.in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_busy"}, 32'(if_u.busy), 32'd1);
        chk({tag, "_rdy_acc"}, 32'(if_u.in_ready), 32'd0);
    endtask

    // Expects out_valid exactly 3 edges after accept, then consumes it (out_ready high).
    task automatic collect(input logic [19:0] eu, input logic [19:0] es, input logic [19:0] er,
                           input string tag);
        repeat (2) begin
            @(negedge clk);
            chk({tag, "_ov_early"}, 32'(if_u.out_valid), 32'd0);
        end
        @(negedge clk);
        chk({tag, "_ov"}, 32'(if_u.out_valid), 32'd1);
        chk({tag, "_res_u"}, 32'(if_u.result), 32'(eu));
        chk({tag, "_res_s"}, 32'(if_s.result), 32'(es));
        chk({tag, "_res_r"}, 32'(if_r.result), 32'(er));
        @(negedge clk);
        chk({tag, "_ov_drop"}, 32'(if_u.out_valid), 32'd0);
        chk({tag, "_rdy_back"}, 32'(if_u.in_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b1;
        img = '0; ker = '0; k5_valid = 1'b0; k5_img = '0; k5_ker = '0;

        // Reset values, then asynchronous release away from any edge.
        repeat (3) @(negedge clk);
        chk("rst_rdy", 32'(if_u.in_ready), 32'd1);
        chk("rst_ov", 32'(if_u.out_valid), 32'd0);
        chk("rst_res", 32'(if_u.result), 32'd0);
        chk("rst_busy", 32'(if_u.busy), 32'd0);
        #3 rst_n = 1'b1;
        @(negedge clk);
        chk("rel_rdy", 32'(if_u.in_ready), 32'd1);
        chk("rel_ov", 32'(if_u.out_valid), 32'd0);
        chk("rel_busy", 32'(if_u.busy), 32'd0);

        // 1..9 with unit kernel.
        start(seq9(), fill3(8'd1), "basic");
        collect(20'd45, 20'd45, 20'd45, "basic");

        // All 0xFF: 255*255*9 unsigned; (-1)*(-1)*9 signed.
        start(fill3(8'hFF), fill3(8'hFF), "max");
        collect(20'd585225, 20'd9, 20'd9, "max");

        // 0x80 x 0x7F: 128*127*9 unsigned; -146304 signed; ReLU clamps.
        start(fill3(8'h80), fill3(8'h7F), "neg");
        collect(20'd146304, 20'hDC480, 20'd0, "neg");

        // -2 x -3 everywhere: 54 signed; 254*253*9 unsigned.
        start(fill3(8'hFE), fill3(8'hFD), "nn");
        collect(20'd578358, 20'd54, 20'd54, "nn");

        // Backpressure in DONE with a competing offer.
        start(seq9(), fill3(8'd1), "bp");
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("bp_ov", 32'(if_u.out_valid), 32'd1);
        img = fill3(8'd2); ker = fill3(8'd3); in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_res", 32'(if_u.result), 32'd45);
            chk("bp_hold_rdy", 32'(if_u.in_ready), 32'd0);
            chk("bp_hold_ov", 32'(if_u.out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_hs_ov", 32'(if_u.out_valid), 32'd0);
        chk("bp_hs_rdy", 32'(if_u.in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp2_busy", 32'(if_u.busy), 32'd1);
        collect(20'd54, 20'd54, 20'd54, "bp2");

        // Abort on the second ACCUM cycle.
        start(fill3(8'd3), fill3(8'd4), "ab");
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_busy", 32'(if_u.busy), 32'd0);
        chk("ab_rdy", 32'(if_u.in_ready), 32'd1);
        chk("ab_res_kept", 32'(if_u.result), 32'd54);
        repeat (4) begin
            @(negedge clk);
            chk("ab_no_ov", 32'(if_u.out_valid), 32'd0);
        end
        start(fill3(8'd3), fill3(8'd4), "ab2");
        collect(20'd108, 20'd108, 20'd108, "ab2");

        // Abort has priority over an offer while idle.
        abort = 1'b1; in_valid = 1'b1; img = fill3(8'd9); ker = fill3(8'd9);
        @(negedge clk);
        abort = 1'b0; in_valid = 1'b0;
        chk("abi_busy", 32'(if_u.busy), 32'd0);
        chk("abi_rdy", 32'(if_u.in_ready), 32'd1);

        // Reset pulse mid-job.
        start(fill3(8'd5), fill3(8'd5), "rs");
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        chk("rs_busy", 32'(if_u.busy), 32'd0);
        chk("rs_res", 32'(if_u.result), 32'd0);
        chk("rs_rdy", 32'(if_u.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rs_no_ov", 32'(if_u.out_valid), 32'd0);
        end
        start(fill3(8'd1), fill3(8'd7), "rs2");
        collect(20'd63, 20'd63, 20'd63, "rs2");

        // 5x5 all ones: 25 after 5 accumulate edges.
        k5_img = fill5(8'd1); k5_ker = fill5(8'd1); k5_valid = 1'b1;
        chk("k5_rdy", 32'(if_5.in_ready), 32'd1);
        @(negedge clk);
        k5_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("k5_ov_early", 32'(if_5.out_valid), 32'd0);
        end
        @(negedge clk);
        chk("k5_ov", 32'(if_5.out_valid), 32'd1);
        chk("k5_res", 32'(if_5.result), 32'd25);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
